// File: rtl/pixclk_pkg.sv
// Shared types, encodings and defaults for the pixel-clock controller.
package pixclk_pkg;

  typedef enum logic [1:0] {
    ST_MEASURE   = 2'd0,
    ST_CFG_REQ   = 2'd1,
    ST_LOCK_WAIT = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_24M      = 2'd0,
    SEL_25M      = 2'd1,
    SEL_36M      = 2'd2,
    SEL_FALLBACK = 2'd3
  } sel_e;

  localparam int unsigned DEF_GATE_CYCLES  = 16384;
  localparam int unsigned DEF_TH0          = 1050;
  localparam int unsigned DEF_TH1          = 1300;
  localparam int unsigned DEF_TH2          = 1800;
  localparam int unsigned DEF_LOCK_HOLD    = 256;
  localparam int unsigned DEF_LOCK_TIMEOUT = 65535;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Maps a non-zero window edge count onto a PLL setting.
  function automatic logic [1:0] band_of(input logic [15:0] cnt,
                                         input logic [15:0] th0,
                                         input logic [15:0] th1,
                                         input logic [15:0] th2);
    logic [1:0] b;
    if (cnt < th0) begin
      b = SEL_24M;
    end else if (cnt < th1) begin
      b = SEL_25M;
    end else if (cnt < th2) begin
      b = SEL_36M;
    end else begin
      b = SEL_FALLBACK;
    end
    return b;
  endfunction

endpackage

// File: rtl/pixclk_freq_meter.sv
// Counts synchronised VIDC divider edges over fixed sys_clk windows.
module pixclk_freq_meter
  import pixclk_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic        sys_clk_i,
  input  logic        reset_n_i,
  input  logic        vidc_div_tgl_i,
  output logic        meas_valid_o,
  output logic [15:0] meas_count_o
);

  localparam int unsigned TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);

  logic          sync1_q, sync2_q, prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   edge_cnt_q, edge_cnt_d;
  logic [15:0]   meas_count_q, meas_count_d;
  logic          meas_valid_q, meas_valid_d;
  logic          edge_s, win_end_s;
  logic [15:0]   cnt_inc_s;

  // An edge seen in the final window cycle is folded into that window's result.
  always_comb begin
    edge_s    = sync2_q ^ prev_q;
    win_end_s = (timer_q == T_LAST);
    if (edge_s && (edge_cnt_q != CNT_MAX)) begin
      cnt_inc_s = edge_cnt_q + 16'd1;
    end else begin
      cnt_inc_s = edge_cnt_q;
    end
    if (win_end_s) begin
      timer_d      = '0;
      edge_cnt_d   = 16'd0;
      meas_count_d = cnt_inc_s;
      meas_valid_d = 1'b1;
    end else begin
      timer_d      = timer_q + TW'(1);
      edge_cnt_d   = cnt_inc_s;
      meas_count_d = meas_count_q;
      meas_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      timer_q      <= '0;
      edge_cnt_q   <= 16'd0;
      meas_count_q <= 16'd0;
      meas_valid_q <= 1'b0;
    end else begin
      sync1_q      <= vidc_div_tgl_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      timer_q      <= timer_d;
      edge_cnt_q   <= edge_cnt_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign meas_valid_o = meas_valid_q;
  assign meas_count_o = meas_count_q;

endmodule

// File: rtl/pixclk_ctrl.sv
// Pixel-clock controller: picks a PLL setting from the measured VIDC rate,
// runs the reconfiguration handshake and gates the pixel-domain reset on lock.
module pixclk_ctrl
  import pixclk_pkg::*;
#(
  parameter int unsigned GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int unsigned TH0          = DEF_TH0,
  parameter int unsigned TH1          = DEF_TH1,
  parameter int unsigned TH2          = DEF_TH2,
  parameter int unsigned LOCK_HOLD    = DEF_LOCK_HOLD,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic        sys_clk_i,
  input  logic        reset_n_i,
  input  logic        vidc_div_tgl_i,
  output logic        pll_cfg_req_o,
  output logic [1:0]  pll_cfg_sel_o,
  input  logic        pll_cfg_ack_i,
  input  logic        pll_locked_i,
  output logic        pix_rst_n_o,
  output logic        vidc_present_o,
  output logic [15:0] meas_count_o
);

  localparam int unsigned HW  = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD + 1) : 1;
  localparam int unsigned TOW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LOCK_HOLD - 1);
  localparam logic [TOW-1:0] TMO_LAST  = TOW'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] TH0_W = 16'(TH0);
  localparam logic [15:0] TH1_W = 16'(TH1);
  localparam logic [15:0] TH2_W = 16'(TH2);

  state_e         state_q;
  logic           req_q;
  logic [1:0]     sel_q;
  logic           pix_rst_n_q;
  logic           present_q;
  logic           diff_q;
  logic [HW-1:0]  hold_q;
  logic [TOW-1:0] tmo_q;

  logic           meas_valid_s;
  logic [15:0]    meas_count_s;
  logic           count_nz_s;
  logic [1:0]     band_s;

  pixclk_freq_meter #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_meter (
    .sys_clk_i     (sys_clk_i),
    .reset_n_i     (reset_n_i),
    .vidc_div_tgl_i(vidc_div_tgl_i),
    .meas_valid_o  (meas_valid_s),
    .meas_count_o  (meas_count_s)
  );

  assign count_nz_s = (meas_count_s != 16'd0);
  assign band_s     = band_of(meas_count_s, TH0_W, TH1_W, TH2_W);

  // diff_q remembers one window whose band disagreed with the active setting.
  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_MEASURE;
      req_q       <= 1'b0;
      sel_q       <= 2'd0;
      pix_rst_n_q <= 1'b0;
      present_q   <= 1'b0;
      diff_q      <= 1'b0;
      hold_q      <= '0;
      tmo_q       <= '0;
    end else begin
      if (meas_valid_s) begin
        present_q <= count_nz_s;
      end else begin
        present_q <= present_q;
      end
      case (state_q)
        ST_MEASURE: begin
          pix_rst_n_q <= 1'b0;
          if (meas_valid_s && count_nz_s) begin
            sel_q   <= band_s;
            req_q   <= 1'b1;
            state_q <= ST_CFG_REQ;
          end
        end
        ST_CFG_REQ: begin
          if (pll_cfg_ack_i && req_q) begin
            req_q   <= 1'b0;
            hold_q  <= '0;
            tmo_q   <= '0;
            state_q <= ST_LOCK_WAIT;
          end else begin
            req_q <= 1'b1;
          end
        end
        ST_LOCK_WAIT: begin
          if (pll_locked_i && (hold_q == HOLD_LAST)) begin
            pix_rst_n_q <= 1'b1;
            diff_q      <= 1'b0;
            state_q     <= ST_RUN;
          end else if (tmo_q == TMO_LAST) begin
            req_q   <= 1'b1;
            state_q <= ST_CFG_REQ;
          end else begin
            hold_q <= pll_locked_i ? (hold_q + HW'(1)) : '0;
            tmo_q  <= tmo_q + TOW'(1);
          end
        end
        ST_RUN: begin
          // Lock loss outranks any measurement result arriving on the same edge.
          if (!pll_locked_i) begin
            pix_rst_n_q <= 1'b0;
            hold_q      <= '0;
            tmo_q       <= '0;
            diff_q      <= 1'b0;
            state_q     <= ST_LOCK_WAIT;
          end else if (meas_valid_s) begin
            if (!count_nz_s) begin
              pix_rst_n_q <= 1'b0;
              diff_q      <= 1'b0;
              state_q     <= ST_MEASURE;
            end else if (band_s != sel_q) begin
              if (diff_q) begin
                pix_rst_n_q <= 1'b0;
                sel_q       <= band_s;
                req_q       <= 1'b1;
                diff_q      <= 1'b0;
                state_q     <= ST_CFG_REQ;
              end else begin
                diff_q <= 1'b1;
              end
            end else begin
              diff_q <= 1'b0;
            end
          end
        end
        default: begin
          req_q       <= 1'b0;
          pix_rst_n_q <= 1'b0;
          state_q     <= ST_MEASURE;
        end
      endcase
    end
  end

  assign pll_cfg_req_o  = req_q;
  assign pll_cfg_sel_o  = sel_q;
  assign pix_rst_n_o    = pix_rst_n_q;
  assign vidc_present_o = present_q;
  assign meas_count_o   = meas_count_s;

endmodule

// File: doc/pixclk_ctrl.md
PIXCLK_CTRL -- requirements
Module: pixclk_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 16384: measurement window length in sys_clk cycles.
REQ-002 Parameters TH0/TH1/TH2, defaults 1050/1300/1800: band thresholds on window edge count.
REQ-003 Parameter LOCK_HOLD, default 256: consecutive pll_locked cycles required before pixel reset release.
REQ-004 Parameter LOCK_TIMEOUT, default 65535: maximum sys_clk cycles spent in LOCK_WAIT.
REQ-005 sys_clk  in  1  sole clock; every flop is clocked by it.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 vidc_div_tgl  in  1  asynchronous; toggles every 8 VIDC clock cycles.
REQ-008 pll_cfg_req  out  1  PLL reconfiguration request.
REQ-009 pll_cfg_sel  out  2  PLL setting; 0=24 MHz, 1=25.175 MHz, 2=36 MHz, 3=fallback.
REQ-010 pll_cfg_ack  in  1  single-cycle acknowledge from PLL configurator.
REQ-011 pll_locked  in  1  PLL lock, already synchronous to sys_clk.
REQ-012 pix_rst_n  out  1  active-low reset for pixel-clock logic.
REQ-013 vidc_present  out  1  high when the last window count was non-zero.
REQ-014 meas_count  out  16  edge count of the last completed window.

Function
REQ-015 vidc_div_tgl shall pass through a 2-flop synchroniser; each change of the synchronised value is one edge.
REQ-016 Edges are counted over windows of exactly GATE_CYCLES cycles; an edge in a window's final cycle belongs to that window; the counter saturates at 16'hFFFF.
REQ-017 At each window end meas_count updates, meas_valid (internal) pulses for 1 cycle, and the counter restarts at 0.
REQ-018 Band: count<TH0 ->0, <TH1 ->1, <TH2 ->2, else 3; count==0 -> "no clock" (no band).
REQ-019 FSM states: MEASURE, CFG_REQ, LOCK_WAIT, RUN.
REQ-020 MEASURE: pix_rst_n=0; on meas_valid with count>0 latch band into pll_cfg_sel, go to CFG_REQ.
REQ-021 CFG_REQ: pll_cfg_req=1 and pll_cfg_sel stable until pll_cfg_ack sampled high; req low the next cycle; go to LOCK_WAIT.
REQ-022 pll_cfg_ack received while pll_cfg_req=0 shall be ignored.
REQ-023 LOCK_WAIT: after LOCK_HOLD consecutive cycles of pll_locked=1 go to RUN; any low cycle restarts the hold count; after LOCK_TIMEOUT cycles return to CFG_REQ (retry, same sel).
REQ-024 RUN: pix_rst_n=1 from the first RUN cycle.
REQ-025 RUN: band differing from pll_cfg_sel on 2 consecutive meas_valid -> pix_rst_n=0 same edge, latch new band, CFG_REQ; a single differing window is ignored.
REQ-026 RUN: meas_valid with count==0 -> pix_rst_n=0, MEASURE, pll_cfg_sel held.
REQ-027 RUN: pll_locked low for 1 cycle -> pix_rst_n=0 next edge, LOCK_WAIT (hold count reset).
REQ-028 Simultaneous lock loss and meas_valid in RUN: lock loss wins.
REQ-029 Measurement runs continuously in all states; vidc_present tracks every meas_valid.

Reset
REQ-030 reset_n low shall immediately force: state MEASURE, pll_cfg_req=0, pll_cfg_sel=0, pix_rst_n=0, vidc_present=0, meas_count=0, all counters and synchroniser flops 0.
REQ-031 Reset mid-handshake shall drop pll_cfg_req asynchronously; the first window after release starts at cycle 0.

Structure
REQ-032 Shared package pixclk_pkg holds the state enum, band/sel encodings and default thresholds.
REQ-033 Sub-module pixclk_freq_meter holds synchroniser, window timer and edge counter; the FSM lives in pixclk_ctrl.

Verification (GATE_CYCLES=1024, LOCK_HOLD=16 for speed)
REQ-034 24 MHz VIDC vs 48 MHz sys_clk (64 edges/window, TH scaled /16) -> sel=0, req until ack, pix_rst_n=1 exactly 16 cycles after lock.
REQ-035 Switch VIDC to 36 MHz in RUN -> one window no action, second window pix_rst_n=0, sel=2, new handshake.
REQ-036 Stop vidc_div_tgl -> next meas_valid gives count=0, vidc_present=0, MEASURE, pix_rst_n=0.
REQ-037 pll_locked held low -> CFG_REQ retry after LOCK_TIMEOUT; 1-cycle lock glitch in RUN -> LOCK_WAIT then re-release.
REQ-038 Spurious ack while idle ignored; reset_n pulse during CFG_REQ -> req=0 asynchronously, all outputs at reset values.
